// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: a DEPTH-entry FIFO between two pipeline stages.
// It has valid/ready handshake, an output-side stall and a flush.
// in_ready_o comes only from occupancy. It never looks at out_ready_i or stall_i,
// so there is no combinational path from the downstream side back upstream.
// Optional feature: define PIPE_STAGE_BUF_PERF_EN to count output-side stall cycles.
module pipe_stage_buf #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       in_valid_i,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [WIDTH-1:0]           out_data_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [31:0]                stall_cnt_o
);

    localparam int unsigned     PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW    = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    // Advance a pointer modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    // Handshake decode; a full buffer refuses a push even if a pop happens on the same edge.
    always_comb begin
        in_ready_o  = (count_q < FullCnt);
        out_valid_o = (count_q != '0);
        out_data_o  = out_valid_o ? mem_q[head_q] : NOP_VALUE;
        push        = in_valid_i & in_ready_o & ~flush_i;
        pop         = out_valid_o & out_ready_i & ~stall_i & ~flush_i;
    end

    // Pointer and occupancy next state; flush wins over everything else.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; no reset needed because out_data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= in_data_i;
    end

    assign count_o = count_q;

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] stall_cnt_q;
    logic        stall_evt;

    assign stall_evt = out_valid_o & (~out_ready_i | stall_i) & ~flush_i;

    // Saturating count of cycles where a valid head could not leave.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf (WIDTH=64, DEPTH=2, non-zero NOP_VALUE).
// A queue model predicts every output before each edge. A vector table adds explicit
// expectations after each edge, and hand sequences cover the reset corners.
module tb_pipe_stage_buf;

    localparam logic [63:0] Nop = 64'hDEAD_BEEF_0000_0001;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0, stall_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [63:0] in_data_i = '0;
    logic        in_ready_o, out_valid_o;
    logic [63:0] out_data_o;
    logic [1:0]  count_o;
    logic [31:0] stall_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [63:0] sbq[$];
    int unsigned m_stall = 0;

    pipe_stage_buf #(.WIDTH(64), .DEPTH(2), .NOP_VALUE(Nop)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_stall(input int unsigned v);
`ifdef PIPE_STAGE_BUF_PERF_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v - v);
`endif
    endfunction

    // Check the current outputs against the model queue.
    task automatic chk_model(input string tag);
        chk({tag, ".count"}, 64'(count_o), 64'(sbq.size()));
        chk({tag, ".valid"}, 64'(out_valid_o), 64'(sbq.size() != 0));
        chk({tag, ".in_ready"}, 64'(in_ready_o), 64'(sbq.size() < 2));
        chk({tag, ".data"}, out_data_o, (sbq.size() != 0) ? sbq[0] : Nop);
        chk({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(exp_stall(m_stall)));
    endtask

    // One clock: drive at negedge, check pre-edge state, update model at posedge.
    task automatic cycle(input logic f, input logic s, input logic iv, input logic [63:0] d,
                         input logic ordy);
        bit m_push, m_pop;
        flush_i = f; stall_i = s; in_valid_i = iv; in_data_i = d; out_ready_i = ordy;
        #1;
        chk_model("pre");
        m_push = iv && (sbq.size() < 2) && !f;
        m_pop  = (sbq.size() != 0) && ordy && !s && !f;
        if ((sbq.size() != 0) && (!ordy || s) && !f) m_stall++;
        @(posedge clk_i);
        if (f) begin
            sbq.delete();
        end else begin
            if (m_pop) void'(sbq.pop_front());
            if (m_push) sbq.push_back(d);
        end
        @(negedge clk_i);
    endtask

    typedef struct {
        logic f, s, iv;
        logic [63:0] d;
        logic ordy;
        logic ev;
        logic [63:0] ed;
        int unsigned ec;
        logic er;
        int unsigned es;
    } vec_t;

    localparam logic [63:0] A = {32'h0000_0004, 32'h0000_0013};
    localparam logic [63:0] B = 64'h1111_2222_3333_4444;
    localparam logic [63:0] C = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] E = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] F = 64'hF1F1_F1F1_F1F1_F1F1;

    vec_t tbl[12];

    initial begin
        logic [63:0] rd;
        // Post-edge expectations: valid, data, count, in_ready, stall count (with counter on).
        tbl[0]  = '{1'b0, 1'b0, 1'b1, A, 1'b0, 1'b1, A,   1, 1'b1, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, B, 1'b0, 1'b1, A,   2, 1'b0, 1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, C, 1'b0, 1'b1, A,   2, 1'b0, 2};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, B,   1, 1'b1, 2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, Nop, 0, 1'b1, 2};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, D, 1'b0, 1'b1, D,   1, 1'b1, 2};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, E, 1'b1, 1'b1, D,   2, 1'b0, 3};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, D,   2, 1'b0, 4};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, D,   2, 1'b0, 5};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, D,   2, 1'b0, 6};
        tbl[10] = '{1'b1, 1'b0, 1'b1, F, 1'b1, 1'b0, Nop, 0, 1'b1, 6};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, Nop, 0, 1'b1, 6};

        // Reset must act before any clock edge.
        #3;
        chk("reset.count", 64'(count_o), 64'd0);
        chk("reset.valid", 64'(out_valid_o), 64'd0);
        chk("reset.data", out_data_o, Nop);
        chk("reset.in_ready", 64'(in_ready_o), 64'd1);
        chk("reset.stall_cnt", 64'(stall_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table vectors: first push, back-to-back overflow, stall while full, flush.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].f, tbl[i].s, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("vec%0d.valid", i), 64'(out_valid_o), 64'(tbl[i].ev));
            chk($sformatf("vec%0d.data", i), out_data_o, tbl[i].ed);
            chk($sformatf("vec%0d.count", i), 64'(count_o), 64'(tbl[i].ec));
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready_o), 64'(tbl[i].er));
            chk($sformatf("vec%0d.stall_cnt", i), 64'(stall_cnt_o), 64'(exp_stall(tbl[i].es)));
        end

        // Steady push+pop at occupancy 1; the pointers wrap several times.
        cycle(1'b0, 1'b0, 1'b1, 64'hA5A5_0000_0000_0001, 1'b1);
        for (int i = 0; i < 10; i++) begin
            rd = {$urandom, $urandom};
            cycle(1'b0, 1'b0, 1'b1, rd, 1'b1);
            chk($sformatf("stream%0d.count", i), 64'(count_o), 64'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk_model("drained");

        // Reset pulse between edges while holding two entries.
        cycle(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_00AA, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_00BB, 1'b0);
        chk("pre_rst.count", 64'(count_o), 64'd2);
        in_valid_i = 1'b1; in_data_i = 64'h0000_0000_0000_00CC; out_ready_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("midrst.count", 64'(count_o), 64'd0);
        chk("midrst.valid", 64'(out_valid_o), 64'd0);
        chk("midrst.data", out_data_o, Nop);
        chk("midrst.in_ready", 64'(in_ready_o), 64'd1);
        chk("midrst.stall_cnt", 64'(stall_cnt_o), 64'd0);
        #1 rst_i = 1'b0;
        sbq.delete();
        m_stall = 0;
        @(posedge clk_i);
        sbq.push_back(64'h0000_0000_0000_00CC);
        @(negedge clk_i);
        chk("postrst.count", 64'(count_o), 64'd1);
        chk("postrst.data", out_data_o, 64'h0000_0000_0000_00CC);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk_model("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
